udp_tx_builder: RTL



---
 rtl/udp_tx_builder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/udp_tx_builder.sv
// Ethernet II + IPv4 + UDP frame builder: 42-byte header with hardware IPv4 checksum, then payload pass-through.
// Optional macro TX_PAD_EN: zero-pad short frames to 60 bytes before the MAC adds FCS.
module udp_tx_builder #(
  parameter logic [47:0] SRC_MAC     = 48'h04A4DD0935C7,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [31:0] SRC_IP      = 32'hC0A80101,
  parameter logic [31:0] DST_IP      = 32'hC0A80102,
  parameter logic [15:0] SRC_PORT    = 16'h1234,
  parameter logic [15:0] DST_PORT    = 16'h1234,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter logic [10:0] MAX_PAYLOAD = 11'd1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] payload_len,
  output logic        busy,
  output logic        len_err,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last
);
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, PAD} state_t;
  state_t state, state_nx;

  logic [10:0]  len_q, idx, last_idx;
  logic [15:0]  ident, csum, tot_len, udp_len, fold2;
  logic [19:0]  sum;
  logic [16:0]  fold1;
  logic         csum_ph, pad_need, tx_hs;
  logic [335:0] hdr_vec;
  logic [5:0]   hdr_pos;
  logic [7:0]   hdr_byte;

`ifdef TX_PAD_EN
  assign pad_need = (len_q < 11'd18);
`else
  assign pad_need = 1'b0;
`endif

  assign tot_len  = 16'd28 + {5'd0, len_q};
  assign udp_len  = 16'd8 + {5'd0, len_q};
  assign last_idx = 11'd41 + len_q;
  assign fold1    = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
  assign fold2    = fold1[15:0] + {15'd0, fold1[16]};
  assign busy     = (state != IDLE);
  assign tx_hs    = tx_valid && tx_ready;

  // Header laid out MSB-first so byte n sits at bits [335-8n -: 8].
  assign hdr_vec  = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, tot_len, ident, 16'h4000,
                     TTL, 8'h11, csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len, 16'h0000};
  assign hdr_pos  = 6'd41 - idx[5:0];
  assign hdr_byte = hdr_vec[{hdr_pos, 3'b000} +: 8];

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    pl_ready = 1'b0;
    case (state)
      IDLE:    if (start && payload_len <= MAX_PAYLOAD) state_nx = CSUM;
      CSUM:    if (csum_ph) state_nx = HDR;
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        tx_last  = (idx == 11'd41) && (len_q == 11'd0) && !pad_need;
        if (tx_ready && idx == 11'd41)
          state_nx = (len_q != 11'd0) ? PAYLOAD : (pad_need ? PAD : IDLE);
      end
      PAYLOAD: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready;
        tx_last  = (idx == last_idx) && !pad_need;
        if (pl_valid && tx_ready && idx == last_idx) state_nx = pad_need ? PAD : IDLE;
      end
      PAD: begin
        tx_valid = 1'b1;
        tx_last  = (idx == 11'd59);
        if (tx_ready && idx == 11'd59) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      idx     <= '0;
      ident   <= '0;
      sum     <= '0;
      csum    <= '0;
      csum_ph <= 1'b0;
      len_err <= 1'b0;
    end else begin
      len_err <= (state == IDLE) && start && (payload_len > MAX_PAYLOAD);
      if (state == IDLE && state_nx == CSUM) begin
        len_q   <= payload_len;
        idx     <= '0;
        csum_ph <= 1'b0;
      end
      // Cycle 1 sums the ten header words (checksum word = 0); cycle 2 folds twice and inverts.
      if (state == CSUM) begin
        csum_ph <= 1'b1;
        if (!csum_ph)
          sum <= 20'(16'h4500) + 20'(tot_len) + 20'(ident) + 20'(16'h4000) + 20'({TTL, 8'h11})
               + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0]) + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
        else
          csum <= ~fold2;
      end
      if (tx_hs) idx <= idx + 11'd1;
      if (tx_hs && tx_last) ident <= ident + 16'd1;
    end
  end
endmodule
